wb_trace_buffer: RTL and testbench
==================================

# wb_trace_buffer

Commit-trace capture block that sits directly downstream of the `riscv` core top and consumes its debug outputs (`reg_write_sig`/`reg_num`/`reg_data`, `wr`/`reade`/`addr`/`wr_data`/`rd_data`). Each retired register write, and optionally each data-memory access, is time-stamped, packed into a fixed-width trace record and buffered in a FIFO. The records are drained over a valid/ready stream to a bench monitor or a serial dumper. Overflow is counted, never stalls the core.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥4.
- `TS_W`, 16: timestamp width.
- `DATA_W`, 32: data field width.
- `clk`  in  1: single clock.
- `reset`  in  1: synchronous, active-high.
- `trace_en`  in  1: capture enable; sampled every cycle.
- `reg_write_sig`  in  1: core register-write strobe.
- `reg_num`  in  5: destination register.
- `reg_data`  in  DATA_W: write-back value.
- `wr`  in  1: data-memory write strobe.
- `reade`  in  1: data-memory read strobe.
- `addr`  in  9: data-memory address.
- `wr_data`  in  DATA_W: store data.
- `rd_data`  in  DATA_W: load data, valid in the same cycle as `reade`.
- `tr_valid`  out  1: record available.
- `tr_data`  out  2+5+9+DATA_W+TS_W: head record `{kind, reg, addr, data, ts}`.
- `tr_ready`  in  1: consumer accepts the head record.
- `tr_count`  out  $clog2(DEPTH)+1: occupancy.
- `tr_overflow`  out  1: sticky; set on any dropped event.
- `tr_drop_cnt`  out  16: dropped events, saturating at 0xFFFF.

## Operation
- Kinds: `REG`=2'b01, `MEMW`=2'b10, `MEMR`=2'b11. 2'b00 never emitted.
- REG event: `trace_en & reg_write_sig & (reg_num != 0)`. Fields: reg=`reg_num`, addr=0, data=`reg_data`.
- Mem event: `trace_en & (wr | reade)`. `wr` has priority: if both are high, one MEMW event is emitted and the read is ignored. Fields: reg=0, addr=`addr`, data=`wr_data` or `rd_data`.
- ts = free-running cycle counter value in the event cycle. The counter resets to 0, increments every cycle and wraps modulo 2^TS_W.
- Up to two events per cycle. Push order is REG first, then mem, so REG occupies the lower FIFO slot.
- Free slots = `DEPTH - tr_count + pop`, where pop = `tr_valid & tr_ready`. A pop in the same cycle frees a slot for that cycle's pushes.
- Two events with one free slot: REG is accepted, mem is dropped.
- Any event with zero free slots is dropped.
- Each drop increments `tr_drop_cnt` (2 if both events drop, saturating) and sets `tr_overflow`.
- `trace_en` low: no events, no drops. Draining continues.
- `tr_overflow` and `tr_drop_cnt` clear only on `reset`.

## Timing
- Reset values:
  - `tr_valid`=0, `tr_data`=0, `tr_count`=0.
  - `tr_overflow`=0, `tr_drop_cnt`=0.
  - timestamp=0, FIFO pointers=0.
- Reset asserted mid-stream discards all buffered records on that edge.
- Capture latency: an event in cycle N is written at the end of N. `tr_valid` is high in N+1 if the FIFO was empty.
- Registered FIFO output, no fall-through. `tr_data` is stable while `tr_valid & !tr_ready`.
- Pop at edge E: the next record is presented in cycle E+1.
- `tr_count` updates at the same edge as push/pop. Range 0..DEPTH.
- Full FIFO with pop plus one push: count unchanged, no drop.
- Pointers wrap modulo DEPTH. Full/empty is distinguished by `tr_count`, not by pointer equality.

## Configuration
- `WB_TRACE_MEM_EN` defined: memory events (MEMW/MEMR) are captured as described.
- `WB_TRACE_MEM_EN` undefined:
  - Only REG events are captured, at most one push per cycle.
  - `wr`/`reade`/`addr`/`wr_data`/`rd_data` are ignored (ports kept).
  - MEMW/MEMR never appear.
  - The dual-push path is removed.

## Structure
- Package `trace_pkg` holds:
  - the `trace_kind_e` enum (REG/MEMW/MEMR);
  - the `trace_rec_t` packed struct `{kind, reg, addr, data, ts}`;
  - the constants `TRACE_ADDR_W`=9 and `TRACE_REG_W`=5.
- One sub-module, `trace_fifo`: synchronous FIFO with 2 push ports (in-order) and 1 registered pop port, exposing count.
- Event qualification, timestamp and drop accounting live in `wb_trace_buffer`.

## Test plan
- **Single REG:** after reset, `trace_en`=1, `reg_write_sig`=1, `reg_num`=5, `reg_data`=0xDEADBEEF at cycle 3, `tr_ready`=1. Expect `tr_valid` in cycle 4 with kind=01, reg=5, data=0xDEADBEEF, ts=3.
- **x0 filter and enable:** a write to reg 0, and any write with `trace_en`=0, produce no record and leave `tr_count`=0.
- **Dual event (macro on):** same cycle, REG x7=0x11 and `wr` addr=0x1FF, `wr_data`=0x22. Expect two records in order: REG, then MEMW addr=0x1FF, data=0x22. `wr`+`reade` together yields only MEMW.
- **Overflow:** `tr_ready`=0, 18 REG events with DEPTH=16. Expect `tr_count`=16, `tr_drop_cnt`=2, `tr_overflow`=1. Draining returns the first 16 records in order.
- **Full with pop:** FIFO full, `tr_ready`=1, one REG event. Expect no drop and `tr_count` remains 16. With one slot free and a dual event: REG is kept and `tr_drop_cnt` +1.
- **Reset mid-stream:** 5 records buffered, `reset` for 1 cycle. Expect all outputs at reset values, the next event with ts=0, and the old records never emitted.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types and constants for the commit-trace capture block.
package trace_pkg;

    localparam int TRACE_ADDR_W = 9;
    localparam int TRACE_REG_W  = 5;
    localparam int TRACE_DATA_W = 32;
    localparam int TRACE_TS_W   = 16;

    typedef enum logic [1:0] {
        KIND_NONE = 2'b00,
        KIND_REG  = 2'b01,
        KIND_MEMW = 2'b10,
        KIND_MEMR = 2'b11
    } trace_kind_e;

    // Record layout for the default data/timestamp widths.
    typedef struct packed {
        trace_kind_e               kind;
        logic [TRACE_REG_W-1:0]    reg_num;
        logic [TRACE_ADDR_W-1:0]   addr;
        logic [TRACE_DATA_W-1:0]   data;
        logic [TRACE_TS_W-1:0]     ts;
    } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with two in-order push ports and a registered head output.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 64,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push0,
    input  logic [W-1:0]  push0_data,
    input  logic          push1,
    input  logic [W-1:0]  push1_data,
    input  logic          pop,
    output logic          rd_valid,
    output logic [W-1:0]  rd_data,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          valid_r;
    logic [W-1:0]  head_r;

    logic          pop_s;
    logic [AW-1:0] wr_ptr_p1_s;
    logic [AW-1:0] rd_ptr_nxt_s;
    logic [CW-1:0] after_pop_s;
    logic [CW-1:0] count_nxt_s;
    logic [W-1:0]  head_nxt_s;

    // Next-state pointers, occupancy and head record; an empty FIFO takes the head straight from push0.
    always_comb begin
        pop_s        = pop & (count_r != {CW{1'b0}});
        wr_ptr_p1_s  = wr_ptr_r + AW'(1);
        rd_ptr_nxt_s = rd_ptr_r + AW'(pop_s);
        after_pop_s  = count_r - CW'(pop_s);
        count_nxt_s  = after_pop_s + CW'(push0) + CW'(push1);
        if (after_pop_s == {CW{1'b0}}) begin
            head_nxt_s = push0 ? push0_data : {W{1'b0}};
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Storage array writes; push1 always lands in the slot after push0.
    always_ff @(posedge clk) begin
        if (push0) begin
            mem_r[wr_ptr_r] <= push0_data;
        end
        if (push1) begin
            mem_r[wr_ptr_p1_s] <= push1_data;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            valid_r  <= 1'b0;
            head_r   <= {W{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_r + AW'(push0) + AW'(push1);
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            valid_r  <= (count_nxt_s != {CW{1'b0}});
            head_r   <= head_nxt_s;
        end
    end

    assign rd_valid = valid_r;
    assign rd_data  = head_r;
    assign count    = count_r;

endmodule

// File: rtl/wb_trace_buffer.sv
// Commit-trace capture: qualifies core events, time-stamps them and buffers records.
// Memory-access capture is enabled by defining WB_TRACE_MEM_EN.
module wb_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16,
    parameter int DATA_W = 32,
    localparam int CW    = $clog2(DEPTH) + 1,
    localparam int REC_W = 2 + TRACE_REG_W + TRACE_ADDR_W + DATA_W + TS_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    trace_en,
    input  logic                    reg_write_sig,
    input  logic [TRACE_REG_W-1:0]  reg_num,
    input  logic [DATA_W-1:0]       reg_data,
    input  logic                    wr,
    input  logic                    reade,
    input  logic [TRACE_ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic [DATA_W-1:0]       rd_data,
    output logic                    tr_valid,
    output logic [REC_W-1:0]        tr_data,
    input  logic                    tr_ready,
    output logic [CW-1:0]           tr_count,
    output logic                    tr_overflow,
    output logic [15:0]             tr_drop_cnt
);

    logic [TS_W-1:0]  ts_r;
    logic             overflow_r;
    logic [15:0]      drop_cnt_r;

    logic             pop_s;
    logic [CW-1:0]    free_s;
    logic             reg_evt_s;
    logic             reg_acc_s;
    logic             mem_evt_s;
    logic             mem_acc_s;
    logic [1:0]       drops_s;
    logic [16:0]      drop_sum_s;
    logic [REC_W-1:0] reg_rec_s;
    logic             push0_s;
    logic [REC_W-1:0] push0_data_s;
    logic             push1_s;
    logic [REC_W-1:0] push1_data_s;

    assign pop_s     = tr_valid & tr_ready;
    assign free_s    = CW'(DEPTH) - tr_count + CW'(pop_s);
    assign reg_evt_s = trace_en & reg_write_sig & (reg_num != {TRACE_REG_W{1'b0}});
    assign reg_rec_s = {KIND_REG, reg_num, {TRACE_ADDR_W{1'b0}}, reg_data, ts_r};

`ifdef WB_TRACE_MEM_EN
    logic [REC_W-1:0] mem_rec_s;

    assign mem_evt_s = trace_en & (wr | reade);
    assign mem_rec_s = {(wr ? KIND_MEMW : KIND_MEMR), {TRACE_REG_W{1'b0}}, addr,
                        (wr ? wr_data : rd_data), ts_r};

    // REG claims the first free slot; mem needs whatever is left after it.
    always_comb begin
        reg_acc_s = reg_evt_s & (free_s != {CW{1'b0}});
        mem_acc_s = mem_evt_s & (free_s >= (reg_evt_s ? CW'(2) : CW'(1)));
        push0_s      = reg_acc_s | mem_acc_s;
        push0_data_s = reg_acc_s ? reg_rec_s : mem_rec_s;
        push1_s      = reg_acc_s & mem_acc_s;
        push1_data_s = mem_rec_s;
    end
`else
    logic unused_mem_s;

    assign unused_mem_s = ^{wr, reade, addr, wr_data, rd_data};
    assign mem_evt_s    = 1'b0;
    assign mem_acc_s    = 1'b0;
    assign reg_acc_s    = reg_evt_s & (free_s != {CW{1'b0}});
    assign push0_s      = reg_acc_s;
    assign push0_data_s = reg_rec_s;
    assign push1_s      = 1'b0;
    assign push1_data_s = {REC_W{1'b0}};
`endif

    assign drops_s    = {1'b0, reg_evt_s & ~reg_acc_s} + {1'b0, mem_evt_s & ~mem_acc_s};
    assign drop_sum_s = {1'b0, drop_cnt_r} + {15'd0, drops_s};

    // Free-running timestamp and sticky drop accounting.
    always_ff @(posedge clk) begin
        if (reset) begin
            ts_r       <= {TS_W{1'b0}};
            overflow_r <= 1'b0;
            drop_cnt_r <= 16'd0;
        end else begin
            ts_r <= ts_r + TS_W'(1);
            if (drops_s != 2'd0) begin
                overflow_r <= 1'b1;
                drop_cnt_r <= drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
            end
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push0      (push0_s),
        .push0_data (push0_data_s),
        .push1      (push1_s),
        .push1_data (push1_data_s),
        .pop        (pop_s),
        .rd_valid   (tr_valid),
        .rd_data    (tr_data),
        .count      (tr_count)
    );

    assign tr_overflow = overflow_r;
    assign tr_drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer with an occupancy model and an expected-record scoreboard.
module tb_wb_trace_buffer;
    import trace_pkg::*;

    localparam int DEPTH = 16;
`ifdef WB_TRACE_MEM_EN
    localparam bit MEM_EN = 1'b1;
`else
    localparam bit MEM_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trace_en = 1'b0;
    logic        reg_write_sig = 1'b0;
    logic [4:0]  reg_num = 5'd0;
    logic [31:0] reg_data = 32'd0;
    logic        wr = 1'b0;
    logic        reade = 1'b0;
    logic [8:0]  addr = 9'd0;
    logic [31:0] wr_data = 32'd0;
    logic [31:0] rd_data = 32'd0;
    logic        tr_valid;
    logic [63:0] tr_data;
    logic        tr_ready = 1'b0;
    logic [4:0]  tr_count;
    logic        tr_overflow;
    logic [15:0] tr_drop_cnt;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] expq[$];
    int          mcount = 0;
    int          mdrop = 0;
    bit          movf = 1'b0;
    logic [15:0] model_ts = 16'd0;

    wb_trace_buffer #(.DEPTH(DEPTH), .TS_W(16), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .trace_en(trace_en),
        .reg_write_sig(reg_write_sig), .reg_num(reg_num), .reg_data(reg_data),
        .wr(wr), .reade(reade), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .tr_valid(tr_valid), .tr_data(tr_data), .tr_ready(tr_ready),
        .tr_count(tr_count), .tr_overflow(tr_overflow), .tr_drop_cnt(tr_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: a record accepted at the coming edge must match the queue head.
    always @(negedge clk) begin
        if (!reset && tr_valid && tr_ready) begin
            n_checks++;
            assert (expq.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_record observed=%0h expected=none", tr_data);
            end
            if (expq.size() > 0) check("record", tr_data, expq.pop_front());
        end
    end

    task automatic tick(input logic re, input logic [4:0] rn, input logic [31:0] rdat,
                        input logic w, input logic r, input logic [8:0] a,
                        input logic [31:0] wd, input logic [31:0] rdd);
        bit pop, reg_e, mem_e, reg_a, mem_a;
        int free;
        trace_rec_t rec;
        reg_write_sig = re; reg_num = rn; reg_data = rdat;
        wr = w; reade = r; addr = a; wr_data = wd; rd_data = rdd;
        pop   = (mcount != 0) && tr_ready;
        free  = DEPTH - mcount + (pop ? 1 : 0);
        reg_e = trace_en && re && (rn != 5'd0);
        mem_e = MEM_EN && trace_en && (w || r);
        reg_a = reg_e && (free >= 1);
        mem_a = mem_e && (free >= (reg_e ? 2 : 1));
        if (reg_a) begin
            rec = '{kind: KIND_REG, reg_num: rn, addr: 9'd0, data: rdat, ts: model_ts};
            expq.push_back(rec);
        end
        if (mem_a) begin
            rec = '{kind: (w ? KIND_MEMW : KIND_MEMR), reg_num: 5'd0, addr: a,
                    data: (w ? wd : rdd), ts: model_ts};
            expq.push_back(rec);
        end
        if (reg_e && !reg_a) begin mdrop++; movf = 1'b1; end
        if (mem_e && !mem_a) begin mdrop++; movf = 1'b1; end
        mcount = mcount - (pop ? 1 : 0) + (reg_a ? 1 : 0) + (mem_a ? 1 : 0);
        @(posedge clk); #1;
        model_ts = model_ts + 16'd1;
    endtask

    task automatic tick_idle();
        tick(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 9'd0, 32'd0, 32'd0);
    endtask

    task automatic tick_reg(input logic [4:0] rn, input logic [31:0] d);
        tick(1'b1, rn, d, 1'b0, 1'b0, 9'd0, 32'd0, 32'd0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1; tr_ready = 1'b0;
        reg_write_sig = 1'b0; wr = 1'b0; reade = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        expq.delete(); mcount = 0; mdrop = 0; movf = 1'b0; model_ts = 16'd0;
        reset = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_count"}, 64'(tr_count), 64'(mcount));
        check({tag, "_valid"}, 64'(tr_valid), 64'(mcount != 0));
        check({tag, "_drops"}, 64'(tr_drop_cnt), 64'(mdrop));
        check({tag, "_ovf"}, 64'(tr_overflow), 64'(movf));
    endtask

    task automatic drain(input string tag);
        tr_ready = 1'b1;
        for (int i = 0; i < 64 && mcount != 0; i++) tick_idle();
        check({tag, "_drained"}, 64'(tr_count), 64'd0);
        check({tag, "_sb_empty"}, 64'(expq.size()), 64'd0);
    endtask

    initial begin
        do_reset(3);
        check("rst_valid", 64'(tr_valid), 64'd0);
        check("rst_data", tr_data, 64'd0);
        check("rst_count", 64'(tr_count), 64'd0);
        check("rst_ovf", 64'(tr_overflow), 64'd0);
        check("rst_drops", 64'(tr_drop_cnt), 64'd0);

        // Single REG event at ts=3
        trace_en = 1'b1; tr_ready = 1'b1;
        repeat (3) tick_idle();
        tick_reg(5'd5, 32'hDEADBEEF);
        check("single_valid", 64'(tr_valid), 64'd1);
        check("single_data", tr_data, {2'b01, 5'd5, 9'd0, 32'hDEADBEEF, 16'd3});
        tick_idle();
        check("single_popped", 64'(tr_count), 64'd0);

        // x0 filter and disabled capture
        tick_reg(5'd0, 32'h12345678);
        check("x0_count", 64'(tr_count), 64'd0);
        trace_en = 1'b0;
        tick_reg(5'd3, 32'h0BADF00D);
        check("dis_count", 64'(tr_count), 64'd0);
        trace_en = 1'b1;

        // Dual event, then simultaneous write+read
        tr_ready = 1'b0;
        tick(1'b1, 5'd7, 32'h11, 1'b1, 1'b0, 9'h1FF, 32'h22, 32'h0);
        check_model("dual");
        tick(1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 9'h0A5, 32'h33, 32'h44);
        tick(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 9'h003, 32'h0, 32'h55);
        check_model("mem_rw");
        drain("mem");

        // Overflow with consumer stalled
        tr_ready = 1'b0;
        for (int i = 0; i < 18; i++) tick_reg(5'((i % 31) + 1), 32'hA000_0000 + 32'(i));
        check("ovf_count", 64'(tr_count), 64'd16);
        check("ovf_drops", 64'(tr_drop_cnt), 64'd2);
        check("ovf_flag", 64'(tr_overflow), 64'd1);

        // Full FIFO with pop plus one push
        tr_ready = 1'b1;
        tick_reg(5'd9, 32'hCAFE_0001);
        check("fullpop_count", 64'(tr_count), 64'd16);
        check("fullpop_drops", 64'(tr_drop_cnt), 64'd2);
        tick_idle();
        tr_ready = 1'b0;
        tick(1'b1, 5'd10, 32'hCAFE_0002, 1'b1, 1'b0, 9'h010, 32'hCAFE_0003, 32'h0);
        check_model("oneslot");
        drain("full");

        // Reset mid-stream
        tr_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick_reg(5'd12, 32'hB000_0000 + 32'(i));
        check("pre_rst_count", 64'(tr_count), 64'd5);
        do_reset(1);
        check("mid_rst_valid", 64'(tr_valid), 64'd0);
        check("mid_rst_data", tr_data, 64'd0);
        check("mid_rst_count", 64'(tr_count), 64'd0);
        check("mid_rst_ovf", 64'(tr_overflow), 64'd0);
        check("mid_rst_drops", 64'(tr_drop_cnt), 64'd0);
        tick_reg(5'd4, 32'h0000_0042);
        check("post_rst_data", tr_data, {2'b01, 5'd4, 9'd0, 32'h0000_0042, 16'd0});
        drain("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
